alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  ID/EX pipeline stage directly upstream of the ALU. Registers decoded operands and control.
//  Resolves RAW hazards with EX/MEM and MEM/WB forwarding, and detects load-use hazards.
//  Drives the ALU inputs PortA, PortB and ALUOP, and carries writeback/memory control into EX.
//  Sits between the decode/register-file read logic and the ALU inside the pipelined datapath.
// PARAMETERS
//  WORD_W      32  data word width (matches word_t)
//  REG_ADDR_W  5   register specifier width
//  OP_W        4   ALU opcode width (matches aluop_t)
// PORTS
//  CLK           in   1           clock, rising edge
//  nRST          in   1           asynchronous active-low reset
//  id_valid      in   1           decode slot holds a real instruction
//  id_rs,id_rt   in   REG_ADDR_W  source register specifiers
//  id_uses_rt    in   1           instruction reads rt as a source (R-type/store/branch)
//  id_rdata1/2   in   WORD_W      register file read data for rs/rt
//  id_imm        in   WORD_W      extended immediate
//  id_alusrc     in   1           1: PortB = immediate; 0: PortB = rt operand
//  id_aluop      in   OP_W        ALU operation
//  id_wsel       in   REG_ADDR_W  destination register
//  id_regwen     in   1           instruction writes a register
//  id_memread    in   1           instruction is a load
//  exmem_regwen  in   1           EX/MEM stage writes a register
//  exmem_wsel    in   REG_ADDR_W  EX/MEM destination register
//  exmem_result  in   WORD_W      EX/MEM ALU result
//  memwb_regwen  in   1           MEM/WB stage writes a register
//  memwb_wsel    in   REG_ADDR_W  MEM/WB destination register
//  memwb_wdat    in   WORD_W      MEM/WB writeback data
//  ex_enable     in   1           pipeline advance; 0 = freeze (memory wait)
//  flush         in   1           squash the instruction entering EX (taken branch/jump)
//  PortA,PortB   out  WORD_W      ALU operands
//  ALUOP         out  OP_W        ALU operation
//  ex_valid      out  1           EX slot holds a real instruction
//  ex_wsel       out  REG_ADDR_W  EX destination register
//  ex_regwen     out  1           EX writes a register (gated by ex_valid)
//  ex_memread    out  1           EX instruction is a load (gated by ex_valid)
//  ex_storedata  out  WORD_W      forwarded rt operand for stores
//  id_stall      out  1           hold the decode stage; a bubble is inserted
// BEHAVIOUR
//  - Reset: all registers and outputs are 0; ALUOP = 0; ex_valid = 0; id_stall = 0.
//  - Latency: one cycle, ID to EX registers. Forwarding muxes are combinational on EX-stage regs.
//  - Load-use (combinational): id_stall = id_valid & ex_valid & ex_memread & ex_wsel != 0
//    & (id_rs == ex_wsel | (id_uses_rt & id_rt == ex_wsel)).
//  - Edge priority: flush > !ex_enable > id_stall > load.
//  - flush: ex_valid, ex_regwen, ex_memread <= 0. Applies even while frozen.
//  - Freeze (!ex_enable): all EX registers hold. id_stall is still computed.
//  - id_stall: bubble inserted; control regs <= 0 and data regs hold.
//  - Load: all regs <= id_*; ex_valid <= id_valid.
//  - Forwarding, per operand with registered source specifier s:
//    s == 0: never forwarded; value is 0.
//    EX/MEM match (exmem_regwen & exmem_wsel == s): exmem_result. EX/MEM beats MEM/WB.
//    else MEM/WB match: memwb_wdat.
//    else the registered read data.
//  - PortA = fwd(rs). ex_storedata = fwd(rt).
//  - PortB = alusrc ? imm : fwd(rt).
//  - nRST low mid-operation: the in-flight instruction is discarded and no bubble is pending.
// CONFIGURATION
//  - ALU_FORWARD_EN defined: forwarding as above, and id_stall covers load-use only.
//  - ALU_FORWARD_EN undefined:
//    no forwarding muxes; PortA/PortB/ex_storedata use the registered read data.
//    id_stall asserts on any rs/used-rt match (non-zero) against a valid ex_regwen writer
//    or an exmem_regwen writer.
//    The register file writes before it reads, so MEM/WB needs no stall.
// TESTING
//  1 Reset: hold nRST=0 with random inputs -> every output 0.
//    Release -> first load appears the cycle after the edge.
//  2 Back-to-back ADD: exmem wsel=3, result=0x10; next op rs=3
//    -> PortA=0x10 (not id_rdata1).
//  3 Dual match: exmem and memwb both wsel=5 (0xAA vs 0xBB)
//    -> forwarded 0xAA; with wsel=0 -> operand 0.
//  4 Load-use: LW to r7 in EX, next op rs=7
//    -> id_stall=1 for one cycle, ex_valid=0 bubble.
//    Next cycle PortA = MEM/WB data.
//  5 flush concurrent with id_stall and ex_enable=0
//    -> ex_valid=0, ex_regwen=0 after the edge.
//  6 Build without ALU_FORWARD_EN, ADD r2 then SUB rs=2
//    -> id_stall asserted two cycles, then correct result.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register feeding the ALU, with operand forwarding and hazard stall detection.
// Optional macro ALU_FORWARD_EN: forwarding from EX/MEM and MEM/WB; without it RAW hazards stall.
module alu_operand_stage #(
  parameter int WORD_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int OP_W       = 4
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic [WORD_W-1:0]     id_rdata1,
  input  logic [WORD_W-1:0]     id_rdata2,
  input  logic [WORD_W-1:0]     id_imm,
  input  logic                  id_alusrc,
  input  logic [OP_W-1:0]       id_aluop,
  input  logic [REG_ADDR_W-1:0] id_wsel,
  input  logic                  id_regwen,
  input  logic                  id_memread,
  input  logic                  exmem_regwen,
  input  logic [REG_ADDR_W-1:0] exmem_wsel,
  input  logic [WORD_W-1:0]     exmem_result,
  input  logic                  memwb_regwen,
  input  logic [REG_ADDR_W-1:0] memwb_wsel,
  input  logic [WORD_W-1:0]     memwb_wdat,
  input  logic                  ex_enable,
  input  logic                  flush,
  output logic [WORD_W-1:0]     PortA,
  output logic [WORD_W-1:0]     PortB,
  output logic [OP_W-1:0]       ALUOP,
  output logic                  ex_valid,
  output logic [REG_ADDR_W-1:0] ex_wsel,
  output logic                  ex_regwen,
  output logic                  ex_memread,
  output logic [WORD_W-1:0]     ex_storedata,
  output logic                  id_stall
);

  logic [REG_ADDR_W-1:0] rs_q, rt_q, wsel_q;
  logic [WORD_W-1:0]     rdata1_q, rdata2_q, imm_q;
  logic                  alusrc_q;
  logic [OP_W-1:0]       aluop_q;
  logic                  valid_q, regwen_q, memread_q;
  logic [WORD_W-1:0]     opnd_a, opnd_b;
  logic                  hazard;

  // True when the decoding instruction reads register w (r0 is never a dependency).
  function automatic logic reads_reg(input logic [REG_ADDR_W-1:0] w,
                                     input logic [REG_ADDR_W-1:0] rs,
                                     input logic [REG_ADDR_W-1:0] rt,
                                     input logic                  uses_rt);
    return (w != '0) && ((rs == w) || (uses_rt && (rt == w)));
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rs_q      <= '0;
      rt_q      <= '0;
      wsel_q    <= '0;
      rdata1_q  <= '0;
      rdata2_q  <= '0;
      imm_q     <= '0;
      alusrc_q  <= 1'b0;
      aluop_q   <= '0;
      valid_q   <= 1'b0;
      regwen_q  <= 1'b0;
      memread_q <= 1'b0;
    end else if (flush) begin
      valid_q   <= 1'b0;
      regwen_q  <= 1'b0;
      memread_q <= 1'b0;
    end else if (ex_enable) begin
      if (id_stall) begin
        valid_q   <= 1'b0;
        regwen_q  <= 1'b0;
        memread_q <= 1'b0;
      end else begin
        rs_q      <= id_rs;
        rt_q      <= id_rt;
        wsel_q    <= id_wsel;
        rdata1_q  <= id_rdata1;
        rdata2_q  <= id_rdata2;
        imm_q     <= id_imm;
        alusrc_q  <= id_alusrc;
        aluop_q   <= id_aluop;
        valid_q   <= id_valid;
        regwen_q  <= id_regwen;
        memread_q <= id_memread;
      end
    end
  end

`ifdef ALU_FORWARD_EN
  // EX/MEM is the younger producer, so it wins over MEM/WB.
  always_comb begin
    opnd_a = rdata1_q;
    if (rs_q == '0)
      opnd_a = '0;
    else if (exmem_regwen && (exmem_wsel == rs_q))
      opnd_a = exmem_result;
    else if (memwb_regwen && (memwb_wsel == rs_q))
      opnd_a = memwb_wdat;

    opnd_b = rdata2_q;
    if (rt_q == '0)
      opnd_b = '0;
    else if (exmem_regwen && (exmem_wsel == rt_q))
      opnd_b = exmem_result;
    else if (memwb_regwen && (memwb_wsel == rt_q))
      opnd_b = memwb_wdat;
  end

  assign hazard = valid_q && memread_q && reads_reg(wsel_q, id_rs, id_rt, id_uses_rt);
`else
  logic unused_fwd;

  assign opnd_a = rdata1_q;
  assign opnd_b = rdata2_q;

  // The register file writes before it reads, so only EX and EX/MEM writers need a stall.
  assign hazard = (valid_q && regwen_q && reads_reg(wsel_q, id_rs, id_rt, id_uses_rt)) ||
                  (exmem_regwen && reads_reg(exmem_wsel, id_rs, id_rt, id_uses_rt));
  assign unused_fwd = ^{exmem_result, memwb_regwen, memwb_wsel, memwb_wdat};
`endif

  assign id_stall     = nRST && id_valid && hazard;
  assign PortA        = opnd_a;
  assign PortB        = alusrc_q ? imm_q : opnd_b;
  assign ex_storedata = opnd_b;
  assign ALUOP        = aluop_q;
  assign ex_valid     = valid_q;
  assign ex_wsel      = wsel_q;
  assign ex_regwen    = valid_q && regwen_q;
  assign ex_memread   = valid_q && memread_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: vector table, directed hazard sequences and
// randomized traffic against an instruction-level model. Honours ALU_FORWARD_EN like the design.
`timescale 1ns/1ps
module tb_alu_operand_stage;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int OP_W       = 4;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_t;
  typedef logic [OP_W-1:0]       aluop_t;

  typedef struct {
    logic   valid;
    reg_t   rs;
    reg_t   rt;
    logic   uses_rt;
    word_t  rd1;
    word_t  rd2;
    word_t  imm;
    logic   alusrc;
    aluop_t aluop;
    reg_t   wsel;
    logic   regwen;
    logic   memread;
  } instr_t;

  typedef struct {
    instr_t in;
    word_t  exp_a;
    word_t  exp_b;
    word_t  exp_store;
  } vec_t;

  logic   CLK = 1'b0;
  logic   nRST;
  logic   id_valid, id_uses_rt, id_alusrc, id_regwen, id_memread;
  reg_t   id_rs, id_rt, id_wsel;
  word_t  id_rdata1, id_rdata2, id_imm;
  aluop_t id_aluop;
  logic   exmem_regwen, memwb_regwen, ex_enable, flush;
  reg_t   exmem_wsel, memwb_wsel;
  word_t  exmem_result, memwb_wdat;

  word_t  PortA, PortB, ex_storedata;
  aluop_t ALUOP;
  logic   ex_valid, ex_regwen, ex_memread, id_stall;
  reg_t   ex_wsel;

  int checks = 0;
  int errors = 0;

  // Model of the instruction currently sitting in EX.
  instr_t slot;

  alu_operand_stage #(.WORD_W(WORD_W), .REG_ADDR_W(REG_ADDR_W), .OP_W(OP_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_aluop(id_aluop), .id_wsel(id_wsel),
    .id_regwen(id_regwen), .id_memread(id_memread),
    .exmem_regwen(exmem_regwen), .exmem_wsel(exmem_wsel), .exmem_result(exmem_result),
    .memwb_regwen(memwb_regwen), .memwb_wsel(memwb_wsel), .memwb_wdat(memwb_wdat),
    .ex_enable(ex_enable), .flush(flush),
    .PortA(PortA), .PortB(PortB), .ALUOP(ALUOP), .ex_valid(ex_valid), .ex_wsel(ex_wsel),
    .ex_regwen(ex_regwen), .ex_memread(ex_memread), .ex_storedata(ex_storedata),
    .id_stall(id_stall)
  );

  always #5 CLK = ~CLK;

  function automatic instr_t mkInstr(input logic valid, input reg_t rs, input reg_t rt,
                                     input logic uses_rt, input word_t rd1, input word_t rd2,
                                     input word_t imm, input logic alusrc, input aluop_t aluop,
                                     input reg_t wsel, input logic regwen, input logic memread);
    instr_t i;
    i.valid = valid;  i.rs = rs;   i.rt = rt;   i.uses_rt = uses_rt;
    i.rd1 = rd1;      i.rd2 = rd2; i.imm = imm; i.alusrc = alusrc;
    i.aluop = aluop;  i.wsel = wsel; i.regwen = regwen; i.memread = memread;
    return i;
  endfunction

  function automatic instr_t randInstr();
    return mkInstr(($urandom_range(0, 7) != 0), reg_t'($urandom_range(0, 3)),
                   reg_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   word_t'($urandom()), word_t'($urandom()), word_t'($urandom()),
                   1'($urandom_range(0, 1)), aluop_t'($urandom_range(0, 15)),
                   reg_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
  endfunction

  function automatic instr_t currentId();
    return mkInstr(id_valid, id_rs, id_rt, id_uses_rt, id_rdata1, id_rdata2, id_imm,
                   id_alusrc, id_aluop, id_wsel, id_regwen, id_memread);
  endfunction

  // Value an operand should take, given its source register and register-file read data.
  function automatic word_t fwdExp(input reg_t s, input word_t rd);
`ifdef ALU_FORWARD_EN
    if (s == 0) return '0;
    if (exmem_regwen && exmem_wsel == s) return exmem_result;
    if (memwb_regwen && memwb_wsel == s) return memwb_wdat;
`endif
    return rd;
  endfunction

  function automatic logic idReads(input reg_t w);
    return (w != 0) && (id_rs == w || (id_uses_rt && id_rt == w));
  endfunction

  function automatic logic stallExp();
    if (!nRST || !id_valid) return 1'b0;
`ifdef ALU_FORWARD_EN
    return slot.valid && slot.memread && idReads(slot.wsel);
`else
    return (slot.valid && slot.regwen && idReads(slot.wsel)) ||
           (exmem_regwen && idReads(exmem_wsel));
`endif
  endfunction

  task automatic clearSlot();
    slot = mkInstr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // What happens to the EX slot at a clock edge, in priority order.
  task automatic modelEdge();
    if (!nRST) clearSlot();
    else if (flush) begin
      slot.valid = 1'b0; slot.regwen = 1'b0; slot.memread = 1'b0;
    end else if (ex_enable) begin
      if (stallExp()) begin
        slot.valid = 1'b0; slot.regwen = 1'b0; slot.memread = 1'b0;
      end else begin
        slot = currentId();
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    modelEdge();
    #1;
  endtask

  task automatic settle();
    if (!nRST) clearSlot();
    @(negedge CLK);
  endtask

  task automatic applyStimulus(input instr_t i);
    id_valid = i.valid;   id_rs = i.rs;       id_rt = i.rt;         id_uses_rt = i.uses_rt;
    id_rdata1 = i.rd1;    id_rdata2 = i.rd2;  id_imm = i.imm;       id_alusrc = i.alusrc;
    id_aluop = i.aluop;   id_wsel = i.wsel;   id_regwen = i.regwen; id_memread = i.memread;
  endtask

  task automatic quiet();
    exmem_regwen = 1'b0; exmem_wsel = '0; exmem_result = '0;
    memwb_regwen = 1'b0; memwb_wsel = '0; memwb_wdat = '0;
    ex_enable = 1'b1;    flush = 1'b0;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    word_t rt_val;
    rt_val = fwdExp(slot.rt, slot.rd2);
    checkVal({tag, " PortA"}, PortA, fwdExp(slot.rs, slot.rd1));
    checkVal({tag, " PortB"}, PortB, slot.alusrc ? slot.imm : rt_val);
    checkVal({tag, " storedata"}, ex_storedata, rt_val);
    checkVal({tag, " ALUOP"}, 32'(ALUOP), 32'(slot.aluop));
    checkVal({tag, " ex_valid"}, 32'(ex_valid), 32'(slot.valid));
    checkVal({tag, " ex_wsel"}, 32'(ex_wsel), 32'(slot.wsel));
    checkVal({tag, " ex_regwen"}, 32'(ex_regwen), 32'(slot.valid && slot.regwen));
    checkVal({tag, " ex_memread"}, 32'(ex_memread), 32'(slot.valid && slot.memread));
    checkVal({tag, " id_stall"}, 32'(id_stall), 32'(stallExp()));
  endtask

  initial begin
    vec_t tbl[5];

    tbl[0].in = mkInstr(1, 1, 2, 1, 32'h1111_1111, 32'h2222_2222, 32'h0000_0033, 0, 4'h2, 9, 1, 0);
    tbl[0].exp_a = 32'h1111_1111; tbl[0].exp_b = 32'h2222_2222; tbl[0].exp_store = 32'h2222_2222;
    tbl[1].in = mkInstr(1, 3, 4, 0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFF0, 1, 4'h6, 10, 1, 0);
    tbl[1].exp_a = 32'hA5A5_A5A5; tbl[1].exp_b = 32'hFFFF_FFF0; tbl[1].exp_store = 32'h5A5A_5A5A;
    tbl[2].in = mkInstr(1, 5, 6, 1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 0, 4'hF, 11, 0, 0);
    tbl[2].exp_a = 32'h0000_0000; tbl[2].exp_b = 32'hFFFF_FFFF; tbl[2].exp_store = 32'hFFFF_FFFF;
    tbl[3].in = mkInstr(1, 31, 30, 1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678, 1, 4'h1, 31, 1, 1);
    tbl[3].exp_a = 32'hDEAD_BEEF; tbl[3].exp_b = 32'h1234_5678; tbl[3].exp_store = 32'hCAFE_F00D;
    tbl[4].in = mkInstr(1, 7, 8, 1, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 0, 4'h3, 7, 1, 0);
    tbl[4].exp_a = 32'h0000_0001; tbl[4].exp_b = 32'h0000_0002; tbl[4].exp_store = 32'h0000_0002;

    // Reset held with random inputs: everything reads as zero.
    nRST = 1'b0;
    clearSlot();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(randInstr());
      exmem_regwen = 1'($urandom_range(0, 1)); exmem_wsel = reg_t'($urandom_range(0, 3));
      exmem_result = word_t'($urandom());
      memwb_regwen = 1'($urandom_range(0, 1)); memwb_wsel = reg_t'($urandom_range(0, 3));
      memwb_wdat = word_t'($urandom());
      ex_enable = 1'($urandom_range(0, 1)); flush = 1'($urandom_range(0, 1));
      settle();
      checkOutput("reset");
      tick();
    end
    checkVal("reset PortA", PortA, 0);
    checkVal("reset PortB", PortB, 0);
    checkVal("reset ALUOP", 32'(ALUOP), 0);
    checkVal("reset ex_valid", 32'(ex_valid), 0);
    checkVal("reset id_stall", 32'(id_stall), 0);

    // Release: the first instruction appears after the first edge.
    quiet();
    nRST = 1'b1;
    applyStimulus(mkInstr(1, 1, 2, 1, 32'h1234, 32'h5678, 0, 0, 4'h5, 20, 1, 0));
    settle();
    checkVal("release pre ex_valid", 32'(ex_valid), 0);
    tick();
    settle();
    checkVal("release ex_valid", 32'(ex_valid), 1);
    checkVal("release PortA", PortA, 32'h1234);
    checkVal("release ALUOP", 32'(ALUOP), 5);

    foreach (tbl[k]) begin
      applyStimulus(tbl[k].in);
      #1;
      checkVal($sformatf("tbl%0d pre stall", k), 32'(id_stall), 0);
      tick();
      settle();
      checkVal($sformatf("tbl%0d PortA", k), PortA, tbl[k].exp_a);
      checkVal($sformatf("tbl%0d PortB", k), PortB, tbl[k].exp_b);
      checkVal($sformatf("tbl%0d storedata", k), ex_storedata, tbl[k].exp_store);
      checkVal($sformatf("tbl%0d ex_valid", k), 32'(ex_valid), 1);
      checkOutput($sformatf("tbl%0d", k));
    end

`ifdef ALU_FORWARD_EN
    // Back-to-back dependency forwarded from EX/MEM.
    applyStimulus(mkInstr(1, 3, 4, 1, 32'h999, 32'h888, 0, 0, 4'h2, 9, 1, 0));
    tick();
    applyStimulus(mkInstr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    exmem_regwen = 1'b1; exmem_wsel = 3; exmem_result = 32'h10;
    settle();
    checkVal("fwd exmem PortA", PortA, 32'h10);
    checkOutput("fwd exmem");

    // Both stages match: EX/MEM wins; r0 is never forwarded.
    quiet();
    applyStimulus(mkInstr(1, 5, 5, 1, 32'h1, 32'h2, 0, 0, 4'h2, 9, 1, 0));
    tick();
    exmem_regwen = 1'b1; exmem_wsel = 5; exmem_result = 32'hAA;
    memwb_regwen = 1'b1; memwb_wsel = 5; memwb_wdat = 32'hBB;
    settle();
    checkVal("dual PortA", PortA, 32'hAA);
    checkVal("dual PortB", PortB, 32'hAA);
    checkVal("dual storedata", ex_storedata, 32'hAA);
    applyStimulus(mkInstr(1, 0, 0, 1, 32'h77, 32'h66, 0, 0, 4'h2, 9, 1, 0));
    tick();
    exmem_wsel = 0; memwb_wsel = 0;
    settle();
    checkVal("r0 PortA", PortA, 0);
    checkVal("r0 PortB", PortB, 0);
    checkOutput("r0");

    // Load-use: one bubble, then the loaded value arrives through MEM/WB.
    quiet();
    applyStimulus(mkInstr(1, 1, 2, 0, 32'h0, 32'h0, 32'h40, 1, 4'h0, 7, 1, 1));
    tick();
    applyStimulus(mkInstr(1, 7, 0, 0, 32'h123, 32'h0, 0, 0, 4'h2, 8, 1, 0));
    settle();
    checkVal("loaduse stall", 32'(id_stall), 1);
    tick();
    exmem_regwen = 1'b1; exmem_wsel = 7; exmem_result = 32'h1000;
    settle();
    checkVal("loaduse bubble ex_valid", 32'(ex_valid), 0);
    checkVal("loaduse stall released", 32'(id_stall), 0);
    checkOutput("loaduse bubble");
    tick();
    exmem_regwen = 1'b0;
    memwb_regwen = 1'b1; memwb_wsel = 7; memwb_wdat = 32'h5555;
    settle();
    checkVal("loaduse PortA", PortA, 32'h5555);
    checkVal("loaduse ex_valid", 32'(ex_valid), 1);
    checkOutput("loaduse");
`else
    // Without forwarding, a dependent op waits out EX and EX/MEM.
    quiet();
    applyStimulus(mkInstr(1, 1, 3, 1, 32'h1, 32'h1, 0, 0, 4'h2, 2, 1, 0));
    settle();
    checkVal("raw add stall", 32'(id_stall), 0);
    tick();
    applyStimulus(mkInstr(1, 2, 4, 1, 32'hBAD, 32'h4, 0, 0, 4'h6, 5, 1, 0));
    settle();
    checkVal("raw stall ex", 32'(id_stall), 1);
    tick();
    exmem_regwen = 1'b1; exmem_wsel = 2; exmem_result = 32'h42;
    settle();
    checkVal("raw stall exmem", 32'(id_stall), 1);
    checkVal("raw bubble ex_valid", 32'(ex_valid), 0);
    tick();
    exmem_regwen = 1'b0;
    memwb_regwen = 1'b1; memwb_wsel = 2; memwb_wdat = 32'h42;
    id_rdata1 = 32'h42;
    settle();
    checkVal("raw stall memwb", 32'(id_stall), 0);
    tick();
    settle();
    checkVal("raw PortA", PortA, 32'h42);
    checkVal("raw ex_valid", 32'(ex_valid), 1);
    checkOutput("raw");
`endif

    // flush beats freeze and stall together.
    quiet();
    applyStimulus(mkInstr(1, 1, 1, 0, 32'h0, 32'h0, 32'h8, 1, 4'h0, 7, 1, 1));
    tick();
    applyStimulus(mkInstr(1, 7, 0, 0, 32'h9, 32'h0, 0, 0, 4'h2, 8, 1, 0));
    ex_enable = 1'b0; flush = 1'b1;
    settle();
    checkVal("flush stall", 32'(id_stall), 1);
    tick();
    settle();
    checkVal("flush ex_valid", 32'(ex_valid), 0);
    checkVal("flush ex_regwen", 32'(ex_regwen), 0);
    checkVal("flush ex_memread", 32'(ex_memread), 0);
    checkOutput("flush");

    // Random traffic with a small register set to provoke hazards.
    for (int c = 0; c < 400; c++) begin
      tick();
      applyStimulus(randInstr());
      exmem_regwen = 1'($urandom_range(0, 1)); exmem_wsel = reg_t'($urandom_range(0, 3));
      exmem_result = word_t'($urandom());
      memwb_regwen = 1'($urandom_range(0, 1)); memwb_wsel = reg_t'($urandom_range(0, 3));
      memwb_wdat = word_t'($urandom());
      ex_enable = ($urandom_range(0, 4) != 0);
      flush = ($urandom_range(0, 7) == 0);
      nRST = ($urandom_range(0, 49) != 0);
      settle();
      checkOutput($sformatf("rand%0d", c));
    end
    nRST = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
